// File: rtl/clk_src_sequencer.sv
// Clock-source switch sequencer: debounces the board select, holds the system in
// reset across the mux change and clkgen relock, and reverts or faults on lock timeout.
module clk_src_sequencer #(
   parameter int   DebounceCycles    = 16,
   parameter int   RstHoldCycles     = 8,
   parameter int   SettleCycles      = 4,
   parameter int   LockTimeoutCycles = 256,
   parameter int   ReleaseCycles     = 16,
   parameter logic SelReset          = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sel_req_i,
   input  logic pll_locked_i,
   output logic clk_sel_o,
   output logic pll_rst_o,
   output logic sys_rst_o,
   output logic busy_o,
   output logic lock_err_o
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MaxCyc = max2(max2(max2(DebounceCycles, RstHoldCycles),
                                     max2(SettleCycles, LockTimeoutCycles)), ReleaseCycles);
   localparam int CW = $clog2(MaxCyc) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_DEBOUNCE, S_HOLD, S_SWITCH, S_LOCK, S_RELEASE, S_FAULT
   } state_t;

   logic   r_sel_meta, r_sel_s, r_lock_meta, r_lock_s;
   state_t r_state, w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic   r_target, r_prev_sel, r_fault_sel, r_reverting, r_switching;
   logic   r_clk_sel, r_lock_err;
   logic   w_target_nxt, w_reverting_nxt, w_switching_nxt, w_err_set;
   logic   w_enter;

   // r_cnt holds cycles spent in the current state; it restarts at 0 on every entry
   always_comb begin
      w_state_nxt     = r_state;
      w_target_nxt    = r_target;
      w_reverting_nxt = r_reverting;
      w_switching_nxt = r_switching;
      w_err_set       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!r_lock_s) begin
               w_state_nxt = S_LOCK;
            end else if (r_sel_s != r_clk_sel) begin
               w_state_nxt  = S_DEBOUNCE;
               w_target_nxt = r_sel_s;
            end
         end
         S_DEBOUNCE: begin
            if (r_sel_s != r_target) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == CW'(DebounceCycles - 1)) begin
               w_state_nxt     = S_HOLD;
               w_switching_nxt = 1'b1;
            end
         end
         S_HOLD: begin
            if (r_cnt == CW'(RstHoldCycles - 1)) w_state_nxt = S_SWITCH;
         end
         S_SWITCH: begin
            if (r_cnt == CW'(SettleCycles - 1)) w_state_nxt = S_LOCK;
         end
         S_LOCK: begin
            if (r_lock_s) begin
               w_state_nxt = S_RELEASE;
            end else if (r_cnt == CW'(LockTimeoutCycles - 1)) begin
               w_err_set = 1'b1;
               // Only one revert attempt per switch; boot or lock-loss timeouts go straight to FAULT
               if (!r_reverting && r_switching) begin
                  w_target_nxt    = r_prev_sel;
                  w_reverting_nxt = 1'b1;
                  w_state_nxt     = S_HOLD;
               end else begin
                  w_state_nxt = S_FAULT;
               end
            end
         end
         S_RELEASE: begin
            if (!r_lock_s) begin
               w_state_nxt = S_LOCK;
            end else if (r_cnt == CW'(ReleaseCycles - 1)) begin
               w_state_nxt     = S_IDLE;
               w_reverting_nxt = 1'b0;
               w_switching_nxt = 1'b0;
            end
         end
         S_FAULT: begin
            if (r_sel_s != r_fault_sel) begin
               w_target_nxt    = r_sel_s;
               w_reverting_nxt = 1'b0;
               w_switching_nxt = 1'b1;
               w_state_nxt     = S_HOLD;
            end
         end
         default: w_state_nxt = S_LOCK;
      endcase
   end

   assign w_enter = (w_state_nxt != r_state);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sel_meta  <= 1'b0;
         r_sel_s     <= 1'b0;
         r_lock_meta <= 1'b0;
         r_lock_s    <= 1'b0;
         r_state     <= S_LOCK;
         r_cnt       <= '0;
         r_target    <= SelReset;
         r_prev_sel  <= SelReset;
         r_fault_sel <= SelReset;
         r_reverting <= 1'b0;
         r_switching <= 1'b0;
         r_clk_sel   <= SelReset;
         r_lock_err  <= 1'b0;
      end else begin
         r_sel_meta  <= sel_req_i;
         r_sel_s     <= r_sel_meta;
         r_lock_meta <= pll_locked_i;
         r_lock_s    <= r_lock_meta;
         r_state     <= w_state_nxt;
         r_cnt       <= w_enter ? '0 : r_cnt + CW'(1);
         r_target    <= w_target_nxt;
         r_reverting <= w_reverting_nxt;
         r_switching <= w_switching_nxt;
         if (w_enter && w_state_nxt == S_SWITCH) begin
            r_prev_sel <= r_clk_sel;
            r_clk_sel  <= r_target;
         end
         if (w_enter && w_state_nxt == S_FAULT) r_fault_sel <= r_sel_s;
         if (w_err_set) r_lock_err <= 1'b1;
      end
   end

   assign clk_sel_o  = r_clk_sel;
   assign lock_err_o = r_lock_err;
   assign pll_rst_o  = (r_state == S_SWITCH);
   assign sys_rst_o  = !(r_state == S_IDLE || r_state == S_DEBOUNCE);
   assign busy_o     = !(r_state == S_IDLE || r_state == S_FAULT);

endmodule
